// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the execute-stage front end: the 4-bit ALU
//   opcode set, MIPS primary opcode and R-type funct constants, the
//   exception codes written to out_exc_code, the decoded-instruction
//   record held in the ID/EX register, and small immediate helpers.
//   No ports; imported by alu_decode and alu_issue.

package alu_issue_pkg;

    localparam int DATA_W = 32;

    // ALU opcodes understood by the downstream combinational ALU
    localparam logic [3:0] ALU_PASSB = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_NOR   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_ADDU  = 4'b1001;
    localparam logic [3:0] ALU_SUBU  = 4'b1010;
    localparam logic [3:0] ALU_SLLV  = 4'b1100;
    localparam logic [3:0] ALU_SRLV  = 4'b1101;
    localparam logic [3:0] ALU_SRAV  = 4'b1110;

    // MIPS primary opcodes handled by this stage
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Exception cause codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Decoded instruction as held in the ID/EX register
    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        dest;
        logic              wen;
        logic              ri;
    } decode_t;

    function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zero_ext16(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

    // Only the trapping add/sub forms may raise an overflow exception
    function automatic logic can_overflow(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode
//   Combinational decoder from a raw MIPS instruction word plus its
//   register operand values to the ALU opcode, ALU operand pair,
//   destination register and write enable. Flags unsupported
//   opcode/funct combinations as reserved instructions.
// Ports:
//   instr   in  32  raw instruction word
//   rs_val  in  32  rs register value
//   rt_val  in  32  rt register value
//   op      out 4   ALU opcode
//   a, b    out 32  ALU operands
//   dest    out 5   destination register number
//   wen     out 1   register write enable (0 for RI or dest==0)
//   ri      out 1   reserved-instruction flag

module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [3:0]  op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  dest,
    output logic        wen,
    output logic        ri
);

    logic [5:0]  opcode;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    // The rs register number is resolved upstream; only its value is used here
    logic unused_rs_field;

    assign opcode   = instr[31:26];
    assign rt_field = instr[20:16];
    assign rd_field = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];

    assign unused_rs_field = ^instr[25:21];

    // Opcode/operand selection. Variable shifts mask rs to 5 bits because
    // the ALU shifts by the full 32-bit inA value.
    always_comb begin
        op   = ALU_PASSB;
        a    = '0;
        b    = '0;
        dest = '0;
        ri   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                a    = rs_val;
                b    = rt_val;
                dest = rd_field;
                case (funct)
                    FN_ADD:  op = ALU_ADD;
                    FN_ADDU: op = ALU_ADDU;
                    FN_SUB:  op = ALU_SUB;
                    FN_SUBU: op = ALU_SUBU;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_XOR:  op = ALU_XOR;
                    FN_NOR:  op = ALU_NOR;
                    FN_SLT:  op = ALU_SLT;
                    FN_SLL: begin
                        op = ALU_SLLV;
                        a  = {27'b0, shamt};
                    end
                    FN_SRL: begin
                        op = ALU_SRLV;
                        a  = {27'b0, shamt};
                    end
                    FN_SRA: begin
                        op = ALU_SRAV;
                        a  = {27'b0, shamt};
                    end
                    FN_SLLV: begin
                        op = ALU_SLLV;
                        a  = {27'b0, rs_val[4:0]};
                    end
                    FN_SRLV: begin
                        op = ALU_SRLV;
                        a  = {27'b0, rs_val[4:0]};
                    end
                    FN_SRAV: begin
                        op = ALU_SRAV;
                        a  = {27'b0, rs_val[4:0]};
                    end
                    default: begin
                        ri   = 1'b1;
                        a    = '0;
                        b    = '0;
                        dest = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                op   = ALU_ADD;
                a    = rs_val;
                b    = sign_ext16(imm);
                dest = rt_field;
            end
            OP_ADDIU: begin
                op   = ALU_ADDU;
                a    = rs_val;
                b    = sign_ext16(imm);
                dest = rt_field;
            end
            OP_SLTI: begin
                op   = ALU_SLT;
                a    = rs_val;
                b    = sign_ext16(imm);
                dest = rt_field;
            end
            OP_ANDI: begin
                op   = ALU_AND;
                a    = rs_val;
                b    = zero_ext16(imm);
                dest = rt_field;
            end
            OP_ORI: begin
                op   = ALU_OR;
                a    = rs_val;
                b    = zero_ext16(imm);
                dest = rt_field;
            end
            OP_XORI: begin
                op   = ALU_XOR;
                a    = rs_val;
                b    = zero_ext16(imm);
                dest = rt_field;
            end
            OP_LUI: begin
                op   = ALU_PASSB;
                a    = rs_val;
                b    = {imm, 16'b0};
                dest = rt_field;
            end
            default: begin
                ri = 1'b1;
            end
        endcase
        wen = !ri && (dest != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Execute-stage front end for ALU instructions. Decodes an offered
//   instruction into the ID/EX register (which drives the external
//   combinational ALU) and captures the ALU result plus exception status
//   into the EX/MEM register. Valid/ready handshake on both sides, flush,
//   and synchronous active-high reset.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           input handshake
//   in_instr, in_pc             instruction word and its PC
//   in_rs_val, in_rt_val        register operand values
//   flush                       drop everything in flight
//   alu_op, alu_a, alu_b        to ALU (from EX register)
//   alu_result/zero/overflow    from ALU, sampled in the same cycle
//   out_valid/out_ready         output handshake
//   out_result, out_zero        registered ALU result and zero flag
//   out_dest, out_wen           writeback register and enable
//   out_exc, out_exc_code       exception flag and cause (12 Ov, 10 RI)
//   out_pc                      PC of the result's instruction

module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs_val,
    input  logic [XLEN-1:0] in_rt_val,
    input  logic            flush,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [4:0]      out_dest,
    output logic            out_wen,
    output logic            out_exc,
    output logic [4:0]      out_exc_code,
    output logic [XLEN-1:0] out_pc
);

    decode_t         dec;
    decode_t         ex_dec;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;

    logic            out_adv;
    logic            ov_taken;
    logic            nxt_wen;
    logic            nxt_exc;
    logic [4:0]      nxt_code;

    alu_decode u_decode (
        .instr  (in_instr),
        .rs_val (in_rs_val),
        .rt_val (in_rt_val),
        .op     (dec.op),
        .a      (dec.a),
        .b      (dec.b),
        .dest   (dec.dest),
        .wen    (dec.wen),
        .ri     (dec.ri)
    );

    // OUT moves when empty or drained; EX can take a new instruction when it
    // is empty or its occupant moves into OUT this cycle.
    assign out_adv  = !out_valid || out_ready;
    assign in_ready = !ex_valid || out_adv;

    assign alu_op = ex_dec.op;
    assign alu_a  = ex_dec.a;
    assign alu_b  = ex_dec.b;

    // Exception resolution for the instruction currently in EX
    always_comb begin
        ov_taken = alu_overflow && can_overflow(ex_dec.op);
        nxt_wen  = ex_dec.wen;
        nxt_exc  = 1'b0;
        nxt_code = EXC_NONE;
        if (ex_dec.ri) begin
            nxt_wen  = 1'b0;
            nxt_exc  = 1'b1;
            nxt_code = EXC_RI;
        end else if (ov_taken) begin
            nxt_wen  = 1'b0;
            nxt_exc  = 1'b1;
            nxt_code = EXC_OV;
        end
    end

    // ID/EX register: payload loads only on an actual accept so the ALU
    // inputs stay put while EX is stalled or empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_dec   <= '0;
            ex_pc    <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (in_ready) begin
            ex_valid <= in_valid;
            if (in_valid) begin
                ex_dec <= dec;
                ex_pc  <= in_pc;
            end
        end
    end

    // EX/MEM register: holds its contents while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_dest     <= '0;
            out_wen      <= 1'b0;
            out_exc      <= 1'b0;
            out_exc_code <= EXC_NONE;
            out_pc       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_adv) begin
            out_valid <= ex_valid;
            if (ex_valid) begin
                out_result   <= alu_result;
                out_zero     <= alu_zero;
                out_dest     <= ex_dec.dest;
                out_wen      <= nxt_wen;
                out_exc      <= nxt_exc;
                out_exc_code <= nxt_code;
                out_pc       <= ex_pc;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue
//   Directed self-checking bench for alu_issue. Provides a behavioural
//   ALU on the alu_* interface and compares the ALU-side and output-side
//   signals against hand-computed values.

module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        flush;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_exc;
    logic [4:0]  out_exc_code;
    logic [31:0] out_pc;

    int checks = 0;
    int passes = 0;

    logic [31:0] m_res;
    logic        m_ov;
    logic [67:0] alu_obs;
    logic [77:0] out_obs;

    alu_issue #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_rs_val    (in_rs_val),
        .in_rt_val    (in_rt_val),
        .flush        (flush),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_dest     (out_dest),
        .out_wen      (out_wen),
        .out_exc      (out_exc),
        .out_exc_code (out_exc_code),
        .out_pc       (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: inA is the shift amount, inB the shifted value
    always_comb begin
        m_res = '0;
        m_ov  = 1'b0;
        case (alu_op)
            4'b0000: m_res = alu_b;
            4'b0001: begin
                m_res = alu_a + alu_b;
                m_ov  = (alu_a[31] == alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            4'b0010: begin
                m_res = alu_a - alu_b;
                m_ov  = (alu_a[31] != alu_b[31]) && (m_res[31] != alu_a[31]);
            end
            4'b0011: m_res = alu_a & alu_b;
            4'b0100: m_res = alu_a | alu_b;
            4'b0101: m_res = alu_a ^ alu_b;
            4'b0110: m_res = ~(alu_a | alu_b);
            4'b0111: m_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1001: m_res = alu_a + alu_b;
            4'b1010: m_res = alu_a - alu_b;
            4'b1100: m_res = alu_b << alu_a;
            4'b1101: m_res = alu_b >> alu_a;
            4'b1110: m_res = $signed(alu_b) >>> alu_a;
            default: m_res = '0;
        endcase
    end

    assign alu_result   = m_res;
    assign alu_zero     = (m_res == 32'd0);
    assign alu_overflow = m_ov;

    assign alu_obs = {alu_op, alu_a, alu_b};
    assign out_obs = {out_valid, out_wen, out_exc, out_exc_code, out_dest,
                      out_zero, out_result, out_pc};

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [77:0] pack_out(input logic v, input logic wen, input logic exc,
                                             input logic [4:0] code, input logic [4:0] dest,
                                             input logic zero, input logic [31:0] res,
                                             input logic [31:0] pc);
        return {v, wen, exc, code, dest, zero, res, pc};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        wen;
        logic        exc;
        logic [4:0]  code;
        logic [4:0]  dest;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    // Present one instruction for one cycle; call at a negedge with in_ready=1
    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [31:0] rs, input logic [31:0] rt);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        in_rs_val = rs;
        in_rt_val = rt;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
        else passes++;
        checks++;
        if (alu_obs !== 68'h0) $display("[TB] FAIL reset_alu: got %h, expected 0", alu_obs);
        else passes++;
        checks++;
        if (out_obs !== 78'h0) $display("[TB] FAIL reset_out: got %h, expected 0", out_obs);
        else passes++;
    endtask

    task automatic test_addi_overflow();
        logic [77:0] exp;
        apply_stimulus(i_type(6'h08, 5'd1, 5'd2, 16'h0001), 32'h100, 32'h7FFFFFFF, 32'h0);
        checks++;
        if (alu_obs !== {4'b0001, 32'h7FFFFFFF, 32'h00000001})
            $display("[TB] FAIL addi_ov_alu: got %h, expected %h", alu_obs,
                     {4'b0001, 32'h7FFFFFFF, 32'h00000001});
        else passes++;
        @(negedge clk);
        exp = pack_out(1'b1, 1'b0, 1'b1, 5'd12, 5'd2, 1'b0, 32'h80000000, 32'h100);
        checks++;
        if (out_obs !== exp) $display("[TB] FAIL addi_ov_out: got %h, expected %h", out_obs, exp);
        else passes++;
    endtask

    task automatic test_sllv();
        logic [77:0] exp;
        apply_stimulus(r_type(5'd3, 5'd4, 5'd6, 5'd0, 6'h04), 32'h104, 32'h00000021, 32'h1);
        checks++;
        if (alu_obs !== {4'b1100, 32'h1, 32'h1})
            $display("[TB] FAIL sllv_alu: got %h, expected %h", alu_obs, {4'b1100, 32'h1, 32'h1});
        else passes++;
        @(negedge clk);
        exp = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd6, 1'b0, 32'h2, 32'h104);
        checks++;
        if (out_obs !== exp) $display("[TB] FAIL sllv_out: got %h, expected %h", out_obs, exp);
        else passes++;
    endtask

    task automatic test_lui();
        logic [77:0] exp;
        apply_stimulus(i_type(6'h0F, 5'd0, 5'd5, 16'h1234), 32'h108, 32'h0000DEAD, 32'h0);
        checks++;
        if (alu_obs !== {4'b0000, 32'h0000DEAD, 32'h12340000})
            $display("[TB] FAIL lui_alu: got %h, expected %h", alu_obs,
                     {4'b0000, 32'h0000DEAD, 32'h12340000});
        else passes++;
        @(negedge clk);
        exp = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd5, 1'b0, 32'h12340000, 32'h108);
        checks++;
        if (out_obs !== exp) $display("[TB] FAIL lui_out: got %h, expected %h", out_obs, exp);
        else passes++;
    endtask

    task automatic test_reserved();
        logic [77:0] exp;
        apply_stimulus(r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'h2B), 32'h10C, 32'h5, 32'h6);
        checks++;
        if (alu_op !== 4'b0000) $display("[TB] FAIL sltu_alu_op: got %h, expected 0", alu_op);
        else passes++;
        @(negedge clk);
        exp = pack_out(1'b1, 1'b0, 1'b1, 5'd10, 5'd0, 1'b1, 32'h0, 32'h10C);
        checks++;
        if (out_obs !== exp) $display("[TB] FAIL sltu_out: got %h, expected %h", out_obs, exp);
        else passes++;
    endtask

    // Full-throughput stream: at step i the ALU side shows vector i-1 and
    // the output register shows vector i-2.
    task automatic test_alu_table();
        logic [77:0] exp;
        vecs[0]  = '{r_type(1,2,3,0,6'h20),  32'h5,        32'h7,        4'h1, 32'h5,        32'h7,        32'hC,        1'b0, 1'b1, 1'b0, 5'd0,  5'd3};
        vecs[1]  = '{r_type(1,2,4,0,6'h22),  32'h5,        32'h5,        4'h2, 32'h5,        32'h5,        32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  5'd4};
        vecs[2]  = '{r_type(1,2,8,4,6'h03),  32'hFFFF,     32'h80000000, 4'hE, 32'h4,        32'h80000000, 32'hF8000000, 1'b0, 1'b1, 1'b0, 5'd0,  5'd8};
        vecs[3]  = '{i_type(6'h0C,1,9,16'hF0F0), 32'hFFFF00FF, 32'h0,    4'h3, 32'hFFFF00FF, 32'h0000F0F0, 32'h000000F0, 1'b0, 1'b1, 1'b0, 5'd0,  5'd9};
        vecs[4]  = '{i_type(6'h0A,1,10,16'hFFFF), 32'hFFFFFFFE, 32'h0,   4'h7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 1'b0, 5'd0,  5'd10};
        vecs[5]  = '{r_type(1,2,0,0,6'h21),  32'h1,        32'h2,        4'h9, 32'h1,        32'h2,        32'h3,        1'b0, 1'b0, 1'b0, 5'd0,  5'd0};
        vecs[6]  = '{r_type(1,2,11,0,6'h27), 32'h0F0F0000, 32'h000000FF, 4'h6, 32'h0F0F0000, 32'h000000FF, 32'hF0F0FF00, 1'b0, 1'b1, 1'b0, 5'd0,  5'd11};
        vecs[7]  = '{r_type(1,2,12,0,6'h06), 32'hFFFFFFE4, 32'h80,       4'hD, 32'h4,        32'h80,       32'h8,        1'b0, 1'b1, 1'b0, 5'd0,  5'd12};
        vecs[8]  = '{r_type(1,2,13,0,6'h21), 32'h7FFFFFFF, 32'h1,        4'h9, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 5'd0,  5'd13};
        vecs[9]  = '{i_type(6'h23,1,2,16'h0), 32'h1,       32'h2,        4'h0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 5'd10, 5'd0};
        vecs[10] = '{i_type(6'h0D,1,14,16'h8001), 32'h00010000, 32'h0,   4'h4, 32'h00010000, 32'h00008001, 32'h00018001, 1'b0, 1'b1, 1'b0, 5'd0,  5'd14};
        vecs[11] = '{r_type(1,2,15,0,6'h23), 32'h0,        32'h1,        4'hA, 32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0,  5'd15};
        vecs[12] = '{r_type(1,2,16,0,6'h22), 32'h80000000, 32'h1,        4'h2, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 5'd12, 5'd16};
        vecs[13] = '{i_type(6'h0E,1,17,16'hFFFF), 32'h0000FFFF, 32'h0,   4'h5, 32'h0000FFFF, 32'h0000FFFF, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0,  5'd17};
        for (int i = 0; i < NV + 2; i++) begin
            if (i >= 1 && i <= NV) begin
                checks++;
                if (alu_obs !== {vecs[i-1].op, vecs[i-1].a, vecs[i-1].b})
                    $display("[TB] FAIL table_alu[%0d]: got %h, expected %h", i-1, alu_obs,
                             {vecs[i-1].op, vecs[i-1].a, vecs[i-1].b});
                else passes++;
            end
            if (i >= 2) begin
                exp = pack_out(1'b1, vecs[i-2].wen, vecs[i-2].exc, vecs[i-2].code, vecs[i-2].dest,
                               vecs[i-2].zero, vecs[i-2].res, 32'h1000 + 32'(4 * (i-2)));
                checks++;
                if (out_obs !== exp)
                    $display("[TB] FAIL table_out[%0d]: got %h, expected %h", i-2, out_obs, exp);
                else passes++;
            end
            checks++;
            if (in_ready !== 1'b1) $display("[TB] FAIL table_in_ready[%0d]: got %b, expected 1", i, in_ready);
            else passes++;
            if (i < NV) begin
                in_valid  = 1'b1;
                in_instr  = vecs[i].instr;
                in_pc     = 32'h1000 + 32'(4 * i);
                in_rs_val = vecs[i].rs;
                in_rt_val = vecs[i].rt;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [77:0] e0;
        logic [77:0] e1;
        logic [77:0] e2;
        e0 = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 32'h2, 32'h200);
        e1 = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd2, 1'b0, 32'h4, 32'h204);
        e2 = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 1'b0, 32'h6, 32'h208);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = r_type(1, 2, 1, 0, 6'h21); in_pc = 32'h200; in_rs_val = 32'h1; in_rt_val = 32'h1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_t0: got %b, expected 1", in_ready);
        else passes++;
        @(negedge clk);
        in_instr = r_type(1, 2, 2, 0, 6'h21); in_pc = 32'h204; in_rs_val = 32'h2; in_rt_val = 32'h2;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_t1: got %b, expected 1", in_ready);
        else passes++;
        @(negedge clk);
        in_instr = r_type(1, 2, 3, 0, 6'h21); in_pc = 32'h208; in_rs_val = 32'h3; in_rt_val = 32'h3;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_t2: got %b, expected 0", in_ready);
        else passes++;
        checks++;
        if (out_obs !== e0) $display("[TB] FAIL b2b_out_t2: got %h, expected %h", out_obs, e0);
        else passes++;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_t3: got %b, expected 0", in_ready);
        else passes++;
        checks++;
        if (out_obs !== e0) $display("[TB] FAIL b2b_hold_t3: got %h, expected %h", out_obs, e0);
        else passes++;
        checks++;
        if (alu_obs !== {4'b1001, 32'h2, 32'h2})
            $display("[TB] FAIL b2b_alu_t3: got %h, expected %h", alu_obs, {4'b1001, 32'h2, 32'h2});
        else passes++;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_t4: got %b, expected 1", in_ready);
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_obs !== e1) $display("[TB] FAIL b2b_out_t5: got %h, expected %h", out_obs, e1);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_obs !== e2) $display("[TB] FAIL b2b_out_t6: got %h, expected %h", out_obs, e2);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %b, expected 0", out_valid);
        else passes++;
    endtask

    task automatic test_flush();
        logic [77:0] exp;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = r_type(1, 2, 21, 0, 6'h21); in_pc = 32'h300; in_rs_val = 32'h1; in_rt_val = 32'h1;
        @(negedge clk);
        in_instr  = r_type(1, 2, 22, 0, 6'h21); in_pc = 32'h304; in_rs_val = 32'h2; in_rt_val = 32'h2;
        @(negedge clk);
        out_ready = 1'b0;
        flush     = 1'b1;
        in_instr  = r_type(1, 2, 23, 0, 6'h21); in_pc = 32'h308; in_rs_val = 32'h3; in_rt_val = 32'h3;
        checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL flush_full: got %b, expected 1", out_valid);
        else passes++;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_cleared: got %b, expected 0", out_valid);
        else passes++;
        out_ready = 1'b1;
        in_instr  = r_type(1, 2, 20, 0, 6'h21); in_pc = 32'h30C; in_rs_val = 32'hA; in_rt_val = 32'h14;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_dropped: got %b, expected 0", out_valid);
        else passes++;
        checks++;
        if (alu_obs !== {4'b1001, 32'hA, 32'h14})
            $display("[TB] FAIL flush_alu: got %h, expected %h", alu_obs, {4'b1001, 32'hA, 32'h14});
        else passes++;
        @(negedge clk);
        exp = pack_out(1'b1, 1'b1, 1'b0, 5'd0, 5'd20, 1'b0, 32'h1E, 32'h30C);
        checks++;
        if (out_obs !== exp) $display("[TB] FAIL flush_next_out: got %h, expected %h", out_obs, exp);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_no_dup: got %b, expected 0", out_valid);
        else passes++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = r_type(1, 2, 24, 0, 6'h21); in_pc = 32'h400; in_rs_val = 32'h5; in_rt_val = 32'h5;
        @(negedge clk);
        in_instr  = r_type(1, 2, 25, 0, 6'h21); in_pc = 32'h404; in_rs_val = 32'h6; in_rt_val = 32'h6;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL midrst_full: got %b, expected 1", out_valid);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_obs !== 78'h0) $display("[TB] FAIL midrst_out: got %h, expected 0", out_obs);
        else passes++;
        checks++;
        if (alu_obs !== 68'h0) $display("[TB] FAIL midrst_alu: got %h, expected 0", alu_obs);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b, expected 1", in_ready);
        else passes++;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL midrst_no_emit: got %b, expected 0", out_valid);
        else passes++;
    endtask

    // Watchdog so a broken handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_addi_overflow();
        test_sllv();
        test_lui();
        test_reserved();
        test_alu_table();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage front end for the MIPS integer datapath: accepts a decoded-register instruction (raw instruction word plus register operand values), encodes it into the 4-bit ALU opcode and operand pair that drive the combinational ALU, and captures the ALU result into an output register for the memory/writeback stage. It owns the ID/EX and EX/MEM registers for ALU instructions, with valid/ready backpressure, flush, and overflow / reserved-instruction exception reporting.

## Interface
Parameters:
- XLEN, 32, datapath width (fixed at 32; parameter for readability only)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_pc  in  32  instruction PC
- in_rs_val  in  32  rs register value
- in_rt_val  in  32  rt register value
- flush  in  1  kill everything in flight
- alu_op  out  4  opcode to ALU
- alu_a  out  32  ALU inA
- alu_b  out  32  ALU inB
- alu_result  in  32  ALU aluout
- alu_zero  in  1  ALU zero
- alu_overflow  in  1  ALU overflow
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  registered ALU result
- out_zero  out  1  registered zero flag
- out_dest  out  5  destination register
- out_wen  out  1  register write enable
- out_exc  out  1  exception raised
- out_exc_code  out  5  12 = Ov, 10 = RI, else 0
- out_pc  out  32  PC of the result's instruction

## Operation
- ALU opcode encoding: 0000 pass-B, 0001 add, 0010 sub, 0011 and, 0100 or, 0101 xor, 0110 nor, 0111 slt, 1001 addu, 1010 subu, 1100 sllv, 1101 srlv, 1110 srav.
- R-type (opcode 0) by funct: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt: a=rs, b=rt. 0x00/0x02/0x03 sll/srl/sra: a={27'b0,shamt}, b=rt, op 1100/1101/1110. 0x04/0x06/0x07 sllv/srlv/srav: a={27'b0,rs[4:0]} (masking mandatory; ALU shifts by all 32 bits of inA), b=rt. dest=rd.
- I-type: 0x08 addi (add), 0x09 addiu (addu), 0x0A slti (slt): b=sign-extended imm. 0x0C andi, 0x0D ori, 0x0E xori: b=zero-extended imm. 0x0F lui: op 0000, b={imm,16'b0}. a=rs, dest=rt.
- Any other opcode/funct: RI exception; op 0000, out_wen=0, out_exc=1, code 10.
- Overflow: alu_overflow high in EX (only possible for add/sub/addi) -> out_wen=0, out_exc=1, code 12; out_result still holds the ALU value.
- dest==0 -> out_wen=0.

## Timing
- Two register stages: EX (ID/EX, drives alu_*) and OUT (EX/MEM). Accept on edge N -> alu_* valid cycle N+1 -> out_valid cycle N+2. Full throughput 1/cycle.
- alu_op/alu_a/alu_b come straight from EX registers; ALU output sampled same cycle (combinational path through ALU).
- OUT advances when !out_valid or out_ready. EX advances into OUT when ex_valid and OUT advances. in_ready = !ex_valid or EX advances (combinational on out_ready).
- out_* stable while out_valid && !out_ready.
- flush: both valids cleared on that edge; input offered same cycle is dropped; flush wins over all.
- Reset: in_ready=1 after reset; out_valid=0, out_wen=0, out_exc=0, out_exc_code=0, out_result=0, out_zero=0, out_dest=0, out_pc=0, alu_op=0000, alu_a=0, alu_b=0.
- Reset mid-stream: same as flush plus register clear; no partial result emitted.

## Structure
- Shared package: ALU opcode localparams (ALU_PASSB..ALU_SRAV), MIPS opcode/funct constants, exception codes EXC_OV=12, EXC_RI=10.
- One sub-module: alu_decode (combinational instr/rs/rt -> op, a, b, dest, wen, ri). Registers and handshake in alu_issue.

## Test plan
- addi rs=0x7FFFFFFF imm=1 -> alu_op 0001, out_exc=1, code 12, out_wen=0 at N+2.
- sllv rs=0x00000021 rt=1 -> alu_a=1, out_result=0x00000002, out_wen=1.
- lui rt=5 imm=0x1234 -> alu_op 0000, out_result=0x12340000, out_dest=5.
- funct 0x2B (sltu) -> out_exc=1, code 10, out_wen=0.
- Back-to-back 3 instrs with out_ready=0 two cycles -> in_ready falls after 2 accepted, out_* held, no loss/duplication, order preserved.
- flush with both stages full -> out_valid=0 next cycle; next accepted instruction appears 2 cycles later.
